// File: rtl/hilo_pkg.sv
// -----------------------------------------------------------------------------
// hilo_pkg -- shared definitions for the HI/LO multiply/divide unit.
//
// Contents:
//   ITER      iteration count of the multiply and divide loops (32)
//   CNT_W     width of the iteration counter
//   CNT_LAST  counter value of the final iteration
//   op_e      request opcodes driven on the op field of hilo_if
//   state_e   control FSM encoding (ST_DIV only when HILO_DIV_EN is defined)
//   magnitude helper returning |v| for signed operands, v otherwise
//
// Configuration macro: HILO_DIV_EN (enables the ST_DIV state).
// -----------------------------------------------------------------------------
package hilo_pkg;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_MADD  = 3'b010,
        OP_MSUB  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_DIV   = 3'b110,
        OP_DIVU  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
`ifdef HILO_DIV_EN
        , ST_DIV = 2'd3
`endif
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude of -2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_if.sv
// -----------------------------------------------------------------------------
// hilo_if -- request/result bundle between the pipeline and hilo_unit.
//
// Signals:
//   start  request strobe (sampled by the unit only while busy is low)
//   op     request opcode (hilo_pkg::op_e)
//   a, b   rs / rt operands
//   hi, lo architectural HI / LO registers
//   busy   iterative operation in progress
//   done   one-cycle completion pulse
//
// Modports: master (pipeline side), slave (hilo_unit side).
// -----------------------------------------------------------------------------
interface hilo_if;
    import hilo_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (output start, op, a, b, input hi, lo, busy, done);
    modport slave  (input start, op, a, b, output hi, lo, busy, done);

endinterface

// File: rtl/hilo_div_core.sv
// -----------------------------------------------------------------------------
// hilo_div_core -- 32-iteration restoring divider datapath.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load_i     capture operands and clear the partial remainder
//   step_i     perform one restoring-division iteration
//   a_i, b_i   dividend / divisor as presented on the request
//   signed_i   treat a_i / b_i as two's complement
//   quot_o     sign-corrected quotient (FFFFFFFF on divide by zero)
//   rem_o      sign-corrected remainder (dividend on divide by zero)
//
// The outputs are only meaningful after ITER steps following a load.
// Instantiated by hilo_unit only when HILO_DIV_EN is defined.
// -----------------------------------------------------------------------------
module hilo_div_core
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        signed_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic [31:0] rem_q, quo_q, dvsr_q, a_q;
    logic        qneg_q, rneg_q, zero_q;

    logic [32:0] shifted_d, diff_d;
    logic [31:0] rem_d, quo_d;
    logic        fits_d;

    // Bring the next dividend bit into the partial remainder and keep the
    // subtraction result only when it does not borrow.
    always_comb begin
        shifted_d = {rem_q, quo_q[31]};
        diff_d    = shifted_d - {1'b0, dvsr_q};
        fits_d    = ~diff_d[32];
        rem_d     = fits_d ? diff_d[31:0] : shifted_d[31:0];
        quo_d     = {quo_q[30:0], fits_d};
    end

    // NOTE: the datapath registers are reset too; it costs little here and
    // keeps the outputs free of X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            a_q    <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (load_i) begin
            rem_q  <= '0;
            quo_q  <= magnitude(a_i, signed_i);
            dvsr_q <= magnitude(b_i, signed_i);
            a_q    <= a_i;
            qneg_q <= signed_i & (a_i[31] ^ b_i[31]);
            rneg_q <= signed_i & a_i[31];
            zero_q <= (b_i == 32'd0);
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    // Magnitude division truncates toward zero; the quotient takes the xor
    // of the operand signs and the remainder the dividend's sign.
    assign quot_o = zero_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_q + 32'd1) : quo_q);
    assign rem_o  = zero_q ? a_q           : (rneg_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit -- MIPS-style HI/LO register pair with an iterative multiplier
// (MULT, MULTU, MADD, MSUB), direct moves (MTHI, MTLO) and an optional
// iterative divider (DIV, DIVU).
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   hilo_if.slave: start/op/a/b request in, hi/lo/busy/done out
//
// Timing: a multiply/divide accepted at edge E0 holds busy from E0 to E33,
// updates HI/LO at E33 and pulses done in the cycle after E33. MTHI/MTLO
// write at the accepting edge and pulse done in the following cycle without
// raising busy. Requests arriving while busy is high are dropped.
//
// Configuration macro: HILO_DIV_EN. When undefined, DIV/DIVU behave as a
// no-op that only pulses done.
// -----------------------------------------------------------------------------
module hilo_unit
    import hilo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    hilo_if.slave bus
);

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      mcand_q;
    logic [63:0]      prod_q;
    logic             neg_q;
    logic [31:0]      hi_q, lo_q;
    logic             busy_q, done_q;

    logic [32:0] acc_sum_d;
    logic [63:0] prod_d, prod_signed_d, mul_res_d;
    logic        req_signed;

    assign req_signed = (bus.op != OP_MULTU);

    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        // Shift-add step: prod_q holds {partial sum, remaining multiplier}.
        acc_sum_d     = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
        prod_d        = {acc_sum_d, prod_q[31:1]};
        prod_signed_d = neg_q ? (~prod_q + 64'd1) : prod_q;
        case (op_q)
            OP_MADD: mul_res_d = {hi_q, lo_q} + prod_signed_d;
            OP_MSUB: mul_res_d = {hi_q, lo_q} - prod_signed_d;
            default: mul_res_d = prod_signed_d;
        endcase
    end

`ifdef HILO_DIV_EN
    logic        div_load, div_step;
    logic [31:0] div_quot, div_rem;

    assign div_load = (state_q == ST_IDLE) && bus.start &&
                      ((bus.op == OP_DIV) || (bus.op == OP_DIVU));
    assign div_step = (state_q == ST_DIV);

    hilo_div_core u_div_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (div_load),
        .step_i   (div_step),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .signed_i (bus.op == OP_DIV),
        .quot_o   (div_quot),
        .rem_o    (div_rem)
    );
`endif

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MTHI: begin
                                hi_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= bus.a;
                                done_q <= 1'b1;
                            end
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                op_q    <= bus.op;
                                mcand_q <= magnitude(bus.b, req_signed);
                                prod_q  <= {32'd0, magnitude(bus.a, req_signed)};
                                neg_q   <= req_signed & (bus.a[31] ^ bus.b[31]);
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= ST_MUL;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
                                op_q    <= bus.op;
                                cnt_q   <= '0;
                                busy_q  <= 1'b1;
                                state_q <= ST_DIV;
`else
                                done_q  <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end

                ST_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FIN;
                    end
                end

`ifdef HILO_DIV_EN
                ST_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_FIN;
                    end
                end
`endif

                ST_FIN: begin
`ifdef HILO_DIV_EN
                    if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
                        hi_q <= div_rem;
                        lo_q <= div_quot;
                    end else
`endif
                    begin
                        {hi_q, lo_q} <= mul_res_d;
                    end
                    // busy falls on the same edge done rises, so they never overlap.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit -- self-checking bench for hilo_unit.
//
// Each request pushes the expected HI/LO and completion latency (edges after
// the accepting edge until done is seen) onto a scoreboard; the entry is
// popped and compared when done arrives. A reference model of HI/LO lives in
// the bench. Compile with the same HILO_DIV_EN setting as the RTL.
// -----------------------------------------------------------------------------
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int LONG_LAT = 33;
    localparam int MAX_WAIT = 60;

    logic clk = 1'b0;
    logic rst;

    hilo_if bus ();

    hilo_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0]        acc;
        logic [63:0]        ps;
        logic [63:0]        pu;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        acc = {hi, lo};
        ps  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        pu  = {32'd0, a} * {32'd0, b};
        sa  = a;
        sb  = b;
        case (op)
            OP_MULT:  return ps;
            OP_MULTU: return pu;
            OP_MADD:  return acc + ps;
            OP_MSUB:  return acc - ps;
            OP_MTHI:  return {a, lo};
            OP_MTLO:  return {hi, a};
            OP_DIV, OP_DIVU: begin
`ifdef HILO_DIV_EN
                if (b == 32'd0)      return {a, 32'hFFFF_FFFF};
                else if (op == OP_DIV) return {32'(sa % sb), 32'(sa / sb)};
                else                 return {a % b, a / b};
`else
                return acc;
`endif
            end
            default: return acc;
        endcase
    endfunction

    function automatic int exp_latency(input op_e op);
        case (op)
            OP_MTHI, OP_MTLO: return 0;
`ifndef HILO_DIV_EN
            OP_DIV, OP_DIVU:  return 0;
`endif
            default:          return LONG_LAT;
        endcase
    endfunction

    task automatic run_op(input string tag, input op_e op, input logic [31:0] a,
                          input logic [31:0] b, input bit inject);
        exp_t        e;
        logic [63:0] r;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          lat;
        r      = model(op, a, b, m_hi, m_lo);
        e.tag  = tag;
        e.hi   = r[63:32];
        e.lo   = r[31:0];
        e.lat  = exp_latency(op);
        old_hi = m_hi;
        old_lo = m_lo;
        m_hi   = e.hi;
        m_lo   = e.lo;
        sb_q.push_back(e);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < MAX_WAIT) begin
            if (lat == 16) begin
                check({tag, "_hold_hi"}, 64'(bus.hi), 64'(old_hi));
                check({tag, "_hold_lo"}, 64'(bus.lo), 64'(old_lo));
            end
            if (inject && lat == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_MTHI;
                bus.a     = 32'h1234_5678;
            end
            if (inject && lat == 6) begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'(1));
        e = sb_q.pop_front();
        check({e.tag, "_latency"},  64'(lat),      64'(e.lat));
        check({e.tag, "_hi"},       64'(bus.hi),   64'(e.hi));
        check({e.tag, "_lo"},       64'(bus.lo),   64'(e.lo));
        check({e.tag, "_busy_off"}, 64'(bus.busy), 64'(0));
        @(posedge clk);
        #1;
        check({e.tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hi",   64'(bus.hi),   64'(0));
        check("reset_lo",   64'(bus.lo),   64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Signed multiply of a negative operand.
        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
        check("mult_neg_hi_const", 64'(bus.hi), 64'(32'hFFFF_FFFF));
        check("mult_neg_lo_const", 64'(bus.lo), 64'(32'hFFFF_FFEB));

        // Largest unsigned product.
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi_const", 64'(bus.hi), 64'(32'hFFFF_FFFE));
        check("multu_max_lo_const", 64'(bus.lo), 64'(32'h0000_0001));

        // Accumulate carrying out of LO, then subtract borrowing through HI.
        run_op("mthi0", OP_MTHI, 32'h0000_0000, 32'h0, 1'b0);
        run_op("mtlo_f", OP_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("madd", OP_MADD, 32'h0000_0001, 32'h0000_0001, 1'b0);
        check("madd_hi_const", 64'(bus.hi), 64'(32'h0000_0001));
        check("madd_lo_const", 64'(bus.lo), 64'(32'h0000_0000));
        run_op("mthi0b", OP_MTHI, 32'h0000_0000, 32'h0, 1'b0);
        run_op("mtlo1", OP_MTLO, 32'h0000_0001, 32'h0, 1'b0);
        run_op("msub", OP_MSUB, 32'h0000_0002, 32'h0000_0001, 1'b0);
        check("msub_hi_const", 64'(bus.hi), 64'(32'hFFFF_FFFF));
        check("msub_lo_const", 64'(bus.lo), 64'(32'hFFFF_FFFF));

        // -2^31 * -1 with an MTHI attempted while busy.
        run_op("mult_min_inject", OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check("inject_ignored_hi", 64'(bus.hi), 64'(32'h0000_0000));

        for (int i = 0; i < 5; i++) begin
            run_op($sformatf("rand%0d", i), op_e'(3'($urandom_range(0, 3))),
                   32'($urandom), 32'($urandom), 1'b0);
        end

`ifdef HILO_DIV_EN
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        check("div_neg_lo_const", 64'(bus.lo), 64'(32'hFFFF_FFFD));
        check("div_neg_hi_const", 64'(bus.hi), 64'(32'hFFFF_FFFF));
        run_op("divu_zero", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b0);
        check("divu_zero_lo_const", 64'(bus.lo), 64'(32'hFFFF_FFFF));
        check("divu_zero_hi_const", 64'(bus.hi), 64'(32'h0000_0007));
        run_op("div_mixed", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
`else
        run_op("div_noop", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op("divu_noop", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b0);
`endif

        // Abort a multiply with reset ten cycles in.
        run_op("pre_abort", OP_MTHI, 32'hAAAA_5555, 32'h0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'h0000_0005;
        bus.b     = 32'h0000_0009;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("abort_busy_before", 64'(bus.busy), 64'(1));
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_hi",   64'(bus.hi),   64'(0));
        check("abort_lo",   64'(bus.lo),   64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'(0));
        check("abort_hi_kept", 64'(bus.hi), 64'(0));

        // Recovery after the abort.
        run_op("post_abort", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request strobe; sampled only when Busy=0.
REQ-005 Op  input  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110 DIV, 111 DIVU.
REQ-006 A  input  32  rs operand.
REQ-007 B  input  32  rt operand.
REQ-008 Hi  output  32  architectural HI register, read by mfhi.
REQ-009 Lo  output  32  architectural LO register, read by mflo.
REQ-010 Busy  output  1  iterative operation in progress; the pipeline stalls mfhi, mflo and HI/LO ops while it is high.
REQ-011 Done  output  1  one-cycle pulse marking request completion.

Function
REQ-012 States SHALL be IDLE, MUL, FIN and DIV (DIV exists only under macro); transitions occur on Clk edges only.
REQ-013 In IDLE with Start=1, MTHI SHALL load Hi<=A and MTLO SHALL load Lo<=A at that edge; Done=1 the next cycle; Busy stays 0.
REQ-014 In IDLE with Start=1, MULT/MULTU/MADD/MSUB SHALL latch A, B and Op, clear the iteration counter, and enter MUL.
REQ-015 MUL SHALL run exactly 32 cycles of unsigned shift-add on operand magnitudes (signed ops use |A|, |B|; MULTU/MADD/MSUB... signedness: MULT, MADD, MSUB signed; MULTU unsigned), then enter FIN.
REQ-016 FIN (1 cycle) SHALL apply the product sign and form a 64-bit result: MULT/MULTU {Hi,Lo}<=P; MADD {Hi,Lo}<={Hi,Lo}+P; MSUB {Hi,Lo}<={Hi,Lo}-P; modulo 2^64, no overflow flag; then IDLE.
REQ-017 Latency: Start sampled at edge E0 -> Busy=1 from E0 through E33, Hi/Lo updated at E33, Done=1 for the cycle following E33 (34 cycles).
REQ-018 Hi/Lo SHALL hold their previous values during MUL/DIV; intermediate values are never visible.
REQ-019 Start while Busy=1 SHALL be ignored entirely (no queueing, no effect on Hi/Lo).
REQ-020 Done SHALL never be high concurrently with Busy.

Reset
REQ-021 Reset=1 SHALL immediately force Hi=0, Lo=0, Busy=0, Done=0, state IDLE, counter 0, regardless of Clk.
REQ-022 Reset during MUL/FIN/DIV SHALL abort the operation; no Done pulse is produced for it.

Configuration
REQ-023 Macro HILO_DIV_EN defined: DIV/DIVU SHALL enter DIV for 32 cycles of restoring division, then FIN writes Lo<=quotient, Hi<=remainder; same 34-cycle latency.
REQ-024 Signed DIV: quotient sign = sign(A) xor sign(B); remainder sign = sign(A); truncation toward zero.
REQ-025 Divide by zero (B=0): Lo<=FFFFFFFF, Hi<=A, no exception.
REQ-026 Macro undefined: Op 110/111 SHALL act as no-op (Hi/Lo unchanged, Busy=0, Done pulse next cycle).

Structure
REQ-027 Package hilo_pkg SHALL hold Op encodings, state encoding and ITER=32.
REQ-028 Division datapath SHALL be sub-module hilo_div_core, instantiated only when HILO_DIV_EN is defined.

Verification
REQ-029 MULT A=FFFFFFFD, B=00000007 -> Hi=FFFFFFFF, Lo=FFFFFFEB; Done exactly 34 cycles after Start edge.
REQ-030 MULTU A=B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001.
REQ-031 MTHI 0, MTLO FFFFFFFF, MADD A=1,B=1 -> Hi=00000001, Lo=00000000; then MSUB A=2,B=1 from Hi=0,Lo=1 -> Hi=Lo=FFFFFFFF.
REQ-032 MTHI A=12345678 asserted while Busy -> ignored; Hi unchanged after completion.
REQ-033 Reset asserted at cycle 10 of MULT -> Hi=Lo=0, Busy=0 immediately; no Done.
REQ-034 With HILO_DIV_EN: DIV A=FFFFFFF9, B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF; DIVU A=7, B=0 -> Lo=FFFFFFFF, Hi=00000007.
